// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath strobes,
// with memory stall/timeout handling, illegal-instruction flag and retired-instruction counter.
module multicycle_ctrl #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic [5:0]         funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         Mem2Reg,
    output logic [1:0]         EXTOp,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal_instr,
    output logic               bus_error,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   instr_retired
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } class_t;

    localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(2);

    localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_t              state_q, state_d;
    logic [5:0]          op_q, funct_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q;
    logic                retire;
    logic                timeout_hit;
    class_t              cls_in, cls_q;

    function automatic class_t classify(input logic [5:0] op, input logic [5:0] fn);
        class_t c;
        c = C_ILL;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: c = C_ADDU;
                    6'b100011: c = C_SUBU;
                    6'b001000: c = C_JR;
                    default:   c = C_ILL;
                endcase
            end
            6'b001101: c = C_ORI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    // DECODE must act on the live IR fields; later states use the copy latched there.
    assign cls_in = classify(OP, funct);
    assign cls_q  = classify(op_q, funct_q);

    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == TO_LAST[WAIT_W-1:0]);

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        retire        = 1'b0;
        PCWrite       = 1'b0;
        PCSrc         = 2'd0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 2'd0;
        Mem2Reg       = 2'd0;
        EXTOp         = 2'd0;
        ALUSrc        = 1'b0;
        ALUOp         = ALU_ADDU;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                if (mem_ready) begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    bus_error = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    MemRead = 1'b1;
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end

            S_DECODE: begin
                case (cls_in)
                    C_J: begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'd2;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_JAL: begin
                        PCWrite  = 1'b1;
                        PCSrc    = 2'd2;
                        RegWrite = 1'b1;
                        RegDst   = 2'd2;
                        Mem2Reg  = 2'd2;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_JR: begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'd3;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_ILL: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (cls_q)
                    C_ADDU: begin
                        ALUOp   = ALU_ADDU;
                        state_d = S_WB;
                    end
                    C_SUBU: begin
                        ALUOp   = ALU_SUBU;
                        state_d = S_WB;
                    end
                    C_ORI: begin
                        ALUSrc  = 1'b1;
                        ALUOp   = ALU_OR;
                        state_d = S_WB;
                    end
                    C_LW, C_SW: begin
                        ALUSrc  = 1'b1;
                        EXTOp   = 2'd1;
                        ALUOp   = ALU_ADDU;
                        state_d = S_MEM;
                    end
                    C_BEQ: begin
                        ALUOp   = ALU_SUBU;
                        PCWrite = Zero;
                        PCSrc   = 2'd1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                if (mem_ready) begin
                    IorD     = 1'b1;
                    MemRead  = (cls_q == C_LW);
                    MemWrite = (cls_q == C_SW);
                    if (cls_q == C_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    bus_error = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    IorD     = 1'b1;
                    MemRead  = (cls_q == C_LW);
                    MemWrite = (cls_q == C_SW);
                    wait_d   = wait_q + WAIT_W'(1);
                end
            end

            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (cls_q == C_ADDU || cls_q == C_SUBU) ? 2'd1 : 2'd0;
                Mem2Reg  = (cls_q == C_LW) ? 2'd1 : 2'd0;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RESET;
            op_q      <= '0;
            funct_q   <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) begin
                op_q    <= OP;
                funct_q <= funct;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign state         = state_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction strobe/latency summaries are compared
// against an instruction-level model, plus directed reset, timeout and boundary steps.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  OP, funct;
    logic        Zero, mem_ready;
    logic        PCWrite, IorD, IRWrite, MemRead, MemWrite, RegWrite, ALUSrc;
    logic        illegal_instr, bus_error;
    logic [1:0]  PCSrc, RegDst, Mem2Reg, EXTOp;
    logic [2:0]  ALUOp;
    logic [2:0]  state;
    logic [31:0] instr_retired;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ALUOP_W(3), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .OP(OP), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .Mem2Reg(Mem2Reg),
        .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .state(state), .instr_retired(instr_retired)
    );

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILLOP, K_ILLFN} kind_t;

    typedef struct {
        int         cycles, memrd, memwr, iord, irw, pcw, last_pcsrc;
        int         regw, rdst, m2r, ill, berr, ret, has_exec;
        logic [5:0] exec_vec;
    } summ_t;

    logic [31:0] trace;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] all_outs();
        return {PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, RegWrite, RegDst, Mem2Reg,
                EXTOp, ALUSrc, ALUOp, illegal_instr, bus_error};
    endfunction

    task automatic encode(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] bad_op [4];
        logic [5:0] bad_fn [3];
        bad_op = '{6'b111111, 6'b001000, 6'b100000, 6'b000101};
        bad_fn = '{6'b100000, 6'b000000, 6'b100010};
        fn = 6'($urandom);
        case (k)
            K_ADDU:  begin op = 6'b000000; fn = 6'b100001; end
            K_SUBU:  begin op = 6'b000000; fn = 6'b100011; end
            K_JR:    begin op = 6'b000000; fn = 6'b001000; end
            K_ORI:   op = 6'b001101;
            K_LW:    op = 6'b100011;
            K_SW:    op = 6'b101011;
            K_BEQ:   op = 6'b000100;
            K_J:     op = 6'b000010;
            K_JAL:   op = 6'b000011;
            K_ILLOP: op = bad_op[$urandom_range(0, 3)];
            default: begin op = 6'b000000; fn = bad_fn[$urandom_range(0, 2)]; end
        endcase
    endtask

    // Instruction-level expectations: fw fetch waits, mw memory waits (mw >= 15 means timeout).
    function automatic summ_t model(input kind_t k, input int fw, input int mw, input bit z);
        summ_t e;
        bit rtype = (k == K_ADDU || k == K_SUBU);
        bit jump  = (k == K_J || k == K_JAL || k == K_JR);
        bit ill   = (k == K_ILLOP || k == K_ILLFN);
        bit memop = (k == K_LW || k == K_SW);
        bit to    = memop && (mw >= 15);
        int mcyc  = to ? 15 : mw + 1;
        int mact  = to ? 14 : mw + 1;
        e = '{default: 0};
        e.irw = 1;
        e.pcw = 1;
        if (jump || ill)          e.cycles = fw + 2;
        else if (k == K_BEQ)      e.cycles = fw + 3;
        else if (rtype || k == K_ORI) e.cycles = fw + 4;
        else if (k == K_SW || to) e.cycles = fw + 3 + mcyc;
        else                      e.cycles = fw + 4 + mcyc;
        e.memrd = fw + 1 + ((k == K_LW) ? mact : 0);
        e.memwr = (k == K_SW) ? mact : 0;
        e.iord  = memop ? mact : 0;
        if (jump) e.pcw++;
        if (k == K_BEQ && z) e.pcw++;
        e.last_pcsrc = (k == K_J || k == K_JAL) ? 2 : (k == K_JR) ? 3 : (k == K_BEQ && z) ? 1 : 0;
        e.regw = (rtype || k == K_ORI || (k == K_LW && !to) || k == K_JAL) ? 1 : 0;
        e.rdst = rtype ? 1 : (k == K_JAL) ? 2 : 0;
        e.m2r  = (k == K_LW && !to) ? 1 : (k == K_JAL) ? 2 : 0;
        e.ill  = ill ? 1 : 0;
        e.berr = to ? 1 : 0;
        e.ret  = (ill || to) ? 0 : 1;
        e.has_exec = (rtype || k == K_ORI || memop || k == K_BEQ) ? 1 : 0;
        case (k)
            K_SUBU, K_BEQ: e.exec_vec = 6'b0_00_001;
            K_ORI:         e.exec_vec = 6'b1_00_010;
            K_LW, K_SW:    e.exec_vec = 6'b1_01_000;
            default:       e.exec_vec = 6'b0_00_000;
        endcase
        return e;
    endfunction

    // Entered at a negedge with the DUT in FETCH; returns at the negedge starting the next FETCH.
    task automatic run_instr(input int n, input kind_t k, input int fw, input int mw, input bit z);
        summ_t e, o;
        int fw_rem = fw;
        int mw_rem = mw;
        bit left = 0;
        bit done = 0;
        logic [5:0] op, fn;
        e = model(k, fw, mw, z);
        o = '{default: 0};
        trace = '0;
        encode(k, op, fn);
        OP = op;
        funct = fn;
        Zero = z;
        for (int i = 0; i < 80; i++) begin
            if (state == 3'd1) begin
                mem_ready = (fw_rem == 0);
                if (fw_rem > 0) fw_rem--;
            end else if (state == 3'd4) begin
                mem_ready = (mw_rem == 0);
                if (mw_rem > 0) mw_rem--;
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            trace = {trace[27:0], 1'b0, state};
            if (MemRead)       o.memrd++;
            if (MemWrite)      o.memwr++;
            if (IorD)          o.iord++;
            if (IRWrite)       o.irw++;
            if (illegal_instr) o.ill++;
            if (bus_error)     o.berr++;
            if (PCWrite) begin o.pcw++; o.last_pcsrc = PCSrc; end
            if (RegWrite) begin o.regw++; o.rdst = RegDst; o.m2r = Mem2Reg; end
            if (state == 3'd3) begin o.has_exec = 1; o.exec_vec = {ALUSrc, EXTOp, ALUOp}; end
            if (state != 3'd1) left = 1;
            o.cycles++;
            @(negedge clk);
            if (left && state == 3'd1) begin
                done = 1;
                break;
            end
        end
        exp_ret += e.ret;
        check($sformatf("i%0d.done", n), 64'(done), 64'd1);
        check($sformatf("i%0d.cycles", n), 64'(o.cycles), 64'(e.cycles));
        check($sformatf("i%0d.memrd", n), 64'(o.memrd), 64'(e.memrd));
        check($sformatf("i%0d.memwr", n), 64'(o.memwr), 64'(e.memwr));
        check($sformatf("i%0d.iord", n), 64'(o.iord), 64'(e.iord));
        check($sformatf("i%0d.irw", n), 64'(o.irw), 64'(e.irw));
        check($sformatf("i%0d.pcw", n), 64'(o.pcw), 64'(e.pcw));
        check($sformatf("i%0d.pcsrc", n), 64'(o.last_pcsrc), 64'(e.last_pcsrc));
        check($sformatf("i%0d.regw", n), 64'(o.regw), 64'(e.regw));
        check($sformatf("i%0d.regdst_m2r", n), 64'({o.rdst, o.m2r}), 64'({e.rdst, e.m2r}));
        check($sformatf("i%0d.illegal", n), 64'(o.ill), 64'(e.ill));
        check($sformatf("i%0d.bus_error", n), 64'(o.berr), 64'(e.berr));
        check($sformatf("i%0d.has_exec", n), 64'(o.has_exec), 64'(e.has_exec));
        if (e.has_exec) check($sformatf("i%0d.exec_ctl", n), 64'(o.exec_vec), 64'(e.exec_vec));
        check($sformatf("i%0d.retired", n), 64'(instr_retired), 64'(exp_ret));
    endtask

    initial begin
        int kidx, fw, mw;
        int berr_early;
        reset = 1'b0;
        OP = '0;
        funct = '0;
        Zero = 1'b0;
        mem_ready = 1'b0;
        trace = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset.state", 64'(state), 64'd0);
        check("reset.outputs", 64'(all_outs()), 64'd0);
        check("reset.retired", 64'(instr_retired), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("release.state", 64'(state), 64'd1);
        check("release.retired", 64'(instr_retired), 64'd0);

        // Directed scenarios
        run_instr(0, K_ADDU, 0, 0, 1'b0);
        check("addu.trace", 64'(trace[15:0]), 64'h1235);
        run_instr(1, K_LW, 0, 3, 1'b0);
        run_instr(2, K_BEQ, 0, 0, 1'b1);
        run_instr(3, K_BEQ, 0, 0, 1'b0);
        run_instr(4, K_JAL, 0, 0, 1'b0);
        check("jal.trace", 64'(trace[7:0]), 64'h12);
        run_instr(5, K_ILLOP, 0, 0, 1'b0);
        run_instr(6, K_LW, 1, 14, 1'b0);
        run_instr(7, K_SW, 0, 15, 1'b0);
        run_instr(8, K_LW, 2, 15, 1'b0);
        run_instr(9, K_JR, 0, 0, 1'b0);

        // FETCH timeout: mem_ready held low, bus_error expected on the 15th cycle only
        berr_early = 0;
        for (int c = 1; c <= 15; c++) begin
            mem_ready = 1'b0;
            #1;
            if (c < 15) begin
                if (bus_error) berr_early++;
            end else begin
                check("fetch_to.bus_error", 64'(bus_error), 64'd1);
                check("fetch_to.strobes", 64'({PCWrite, MemRead, IRWrite}), 64'd0);
            end
            @(negedge clk);
        end
        check("fetch_to.early", 64'(berr_early), 64'd0);
        check("fetch_to.state", 64'(state), 64'd1);
        check("fetch_to.retired", 64'(instr_retired), 64'(exp_ret));

        // Randomized instruction stream
        for (int n = 10; n < 50; n++) begin
            kidx = $urandom_range(0, 10);
            fw = $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            run_instr(n, kind_t'(kidx), fw, mw, 1'($urandom));
        end

        // Reset asserted mid-MEM discards the instruction and clears the counter
        OP = 6'b100011;
        funct = '0;
        for (int c = 0; c < 10 && state != 3'd4; c++) begin
            mem_ready = 1'b1;
            @(negedge clk);
        end
        check("midmem.reached", 64'(state), 64'd4);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midmem.state", 64'(state), 64'd0);
        check("midmem.outputs", 64'(all_outs()), 64'd0);
        check("midmem.retired", 64'(instr_retired), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midmem.refetch", 64'(state), 64'd1);
        exp_ret = 0;
        run_instr(50, K_SW, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
